ram_sp_arbiter: RTL

- Initiator/controller for a single-port RAM with one enable, one write-enable and a one-cycle registered read.
- Accepts independent write and read request streams over valid/ready.
- Arbitrates round-robin onto the single RAM port.
- Captures read data one cycle after issue and returns it in order over a valid/ready response stream with backpressure.

---
 rtl/ram_sp_arbiter_pkg.sv | 13 +
 rtl/ram_sp_rsp_buf.sv | 64 ++++++
 rtl/ram_sp_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/ram_sp_arbiter_pkg.sv
// Shared types and sizing for the single-port RAM arbiter and its response buffer.
package ram_sp_arbiter_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WRITE,
        GRANT_READ
    } grant_t;

    localparam int unsigned RSP_DEPTH_C = 2;
    localparam int unsigned RSP_CNT_W_C = $clog2(RSP_DEPTH_C + 1);

endpackage

// File: rtl/ram_sp_rsp_buf.sv
// Two-entry in-order response FIFO with a registered head; push and pop may coincide at any fill.
module ram_sp_rsp_buf
    import ram_sp_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH_P-1:0] push_data,
    input  logic                    pop,
    output logic [RSP_CNT_W_C-1:0]  count,
    output logic                    head_valid,
    output logic [DATA_WIDTH_P-1:0] head_data
);

    localparam logic [RSP_CNT_W_C-1:0] CNT_ONE_C  = RSP_CNT_W_C'(1);
    localparam logic [RSP_CNT_W_C-1:0] CNT_FULL_C = RSP_CNT_W_C'(RSP_DEPTH_C);

    logic [RSP_CNT_W_C-1:0]  count_q;
    logic [DATA_WIDTH_P-1:0] head_q;
    logic [DATA_WIDTH_P-1:0] tail_q;
    logic                    pop_eff;

    assign pop_eff = pop && (count_q != '0);

    // Entries shift toward the head on pop so the output is always straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (count_q == '0) head_q <= push_data;
                    else               tail_q <= push_data;
                    count_q <= count_q + CNT_ONE_C;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_ONE_C;
                end
                2'b11: begin
                    if (count_q == CNT_ONE_C) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_q;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop_eff && (count_q == CNT_FULL_C)));

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin write/read initiator for a single-port RAM with one-cycle registered read,
// returning read data in order through a credit-limited two-entry response buffer.
module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH_P-1:0] wr_addr,
    input  logic [DATA_WIDTH_P-1:0] wr_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_WIDTH_P-1:0] rd_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH_P-1:0] rsp_data,
    output logic                    ram_enable,
    output logic                    ram_write_enable,
    output logic [ADDR_WIDTH_P-1:0] ram_address,
    output logic [DATA_WIDTH_P-1:0] ram_data_ingress,
    input  logic [DATA_WIDTH_P-1:0] ram_data_egress
);

    localparam logic [RSP_CNT_W_C-1:0] OCC_FULL_C = RSP_CNT_W_C'(RSP_DEPTH_C);

    grant_t                 grant;
    grant_t                 last_grant_q;
    logic                   read_in_flight_q;
    logic [RSP_CNT_W_C-1:0] buf_count;
    logic [RSP_CNT_W_C-1:0] occupancy;
    logic                   rsp_pop;
    logic                   read_ok;

    assign rsp_pop   = rsp_valid && rsp_ready;
    // A read in flight already owns a buffer slot, so it counts against the credit.
    assign occupancy = buf_count + RSP_CNT_W_C'(read_in_flight_q);
    assign read_ok   = (occupancy < OCC_FULL_C) || ((occupancy == OCC_FULL_C) && rsp_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q     <= GRANT_WRITE;
            read_in_flight_q <= 1'b0;
        end else begin
            read_in_flight_q <= (grant == GRANT_READ);
            if (grant != GRANT_NONE) last_grant_q <= grant;
        end
    end

    always_comb begin
        grant = GRANT_NONE;
        if (wr_valid && rd_valid && read_ok) begin
            grant = (last_grant_q == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
        end else if (wr_valid) begin
            grant = GRANT_WRITE;
        end else if (rd_valid && read_ok) begin
            grant = GRANT_READ;
        end
    end

    always_comb begin
        wr_ready         = 1'b0;
        rd_ready         = 1'b0;
        ram_enable       = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = wr_addr;
        ram_data_ingress = wr_data;
        case (grant)
            GRANT_WRITE: begin
                wr_ready         = 1'b1;
                ram_enable       = 1'b1;
                ram_write_enable = 1'b1;
            end
            GRANT_READ: begin
                rd_ready    = 1'b1;
                ram_enable  = 1'b1;
                ram_address = rd_addr;
            end
            default: ;
        endcase
    end

    ram_sp_rsp_buf #(
        .DATA_WIDTH_P(DATA_WIDTH_P)
    ) u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (read_in_flight_q),
        .push_data (ram_data_egress),
        .pop       (rsp_pop),
        .count     (buf_count),
        .head_valid(rsp_valid),
        .head_data (rsp_data)
    );

endmodule
